// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, segment patterns and scan state type for the
// 4-digit multiplexed 7-segment display controller.
package disp_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low gfedcba segment lookup.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure table lookup; the top feeds it the currently selected digit.
  assign seg = SEG_PAT[nib];

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan of four common-anode 7-segment digits.
// A staged value (LOAD) is copied into the displayed shadow only at a frame
// boundary (digit 3 -> digit 0) or while scanning is disabled, so a frame
// never shows a mix of old and new digits. Each digit slot starts with GUARD
// blank cycles to suppress ghosting. Expects TICK_DIV >= 2 and
// 1 <= GUARD < TICK_DIV.
// Optional build macro: DISP_LZB_EN enables leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] DIGITS,
  input  logic [3:0]  DP_IN,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        FRAME,
  output logic        PEND
);

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [1:0]    IDX_LAST  = 2'(NDIG - 1);

  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          slot_end;
  logic          wrap;
  logic          commit;

  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [19:0]   staged;

  logic [3:0]    nibble;
  logic [6:0]    dec_pat;
  logic [6:0]    seg_pat;
  logic          lead_blank;
  logic [3:0]    an_on;
  logic [7:0]    seg_on;

  // Slot counter / digit index advance and commit qualification.
  always_comb begin
    slot_end = (cnt == CNT_LAST);
    wrap     = slot_end && (idx == IDX_LAST);
    cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
    idx_nxt  = slot_end ? idx + 2'd1 : idx;
    commit   = PEND && (wrap || !EN);
  end

  seg7_decode u_dec (
    .nib (nibble),
    .seg (dec_pat)
  );

`ifdef DISP_LZB_EN
  // Blank digits above the most significant non-zero nibble; digit 0 always shows.
  always_comb begin
    lead_blank = 1'b0;
    case (idx)
      2'd3:    lead_blank = (shadow[15:12] == 4'h0);
      2'd2:    lead_blank = (shadow[15:8]  == 8'h00);
      2'd1:    lead_blank = (shadow[15:4]  == 12'h000);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Drive values for the selected digit. The shadow only changes on edges that
  // lead into a blank cycle, so the current shadow is always the one to show.
  always_comb begin
    nibble  = shadow[{idx, 2'b00} +: 4];
    an_on   = ~(4'b0001 << idx);
    seg_pat = lead_blank ? SEG_BLANK : dec_pat;
    seg_on  = {~shadow_dp[idx], seg_pat};
  end

  // Scan FSM: guard blanking then digit drive, with registered pin outputs.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
      AN    <= 4'hF;
      SEG   <= 8'hFF;
      FRAME <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      FRAME <= wrap;
      case (state)
        BLANK: begin
          if (cnt_nxt == CNT_GUARD) begin
            state <= ON;
            AN    <= an_on;
            SEG   <= seg_on;
          end else begin
            AN    <= 4'hF;
            SEG   <= 8'hFF;
          end
        end
        ON: begin
          if (slot_end) begin
            state <= BLANK;
            AN    <= 4'hF;
            SEG   <= 8'hFF;
          end else begin
            AN    <= an_on;
            SEG   <= seg_on;
          end
        end
        default: begin
          state <= BLANK;
          AN    <= 4'hF;
          SEG   <= 8'hFF;
        end
      endcase
    end
  end

  // Staging and tear-free commit: a commit takes the pre-edge staged value,
  // while a simultaneous LOAD re-arms PEND for the next boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow    <= '0;
      shadow_dp <= '0;
      staged    <= '0;
      PEND      <= 1'b0;
    end else begin
      if (commit) begin
        {shadow_dp, shadow} <= staged;
      end
      if (LOAD) begin
        staged <= {DP_IN, DIGITS};
        PEND   <= 1'b1;
      end else if (commit) begin
        PEND   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed scenarios plus randomized traffic for
// disp_scan_ctrl, checked against a frame-position reference model.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int T  = 8;
  localparam int G  = 2;
  localparam int FP = 4 * T;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame, pend;

  int checks = 0;
  int errors = 0;

  disp_scan_ctrl #(.TICK_DIV(T), .GUARD(G)) dut (
    .CLK    (clk),
    .RST    (rst),
    .EN     (en),
    .LOAD   (load),
    .DIGITS (digits),
    .DP_IN  (dp_in),
    .AN     (an),
    .SEG    (seg),
    .FRAME  (frame),
    .PEND   (pend)
  );

  always #5 clk = ~clk;

  // Expected segment pattern for digit d of value v.
  function automatic logic [6:0] exp_pat(input logic [15:0] v, input int d);
`ifdef DISP_LZB_EN
    int hi;
    hi = 0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) hi = k;
    if (d > hi) return 7'h7F;
`endif
    return PAT[v[4*d +: 4]];
  endfunction

  // Reference model: position within a frame of 4*T cycles.
  int          m_pos;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [19:0] m_stg;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_frame;

  always @(posedge clk) begin : ref_model
    bit fr, cm;
    int off, dg;
    if (rst) begin
      m_pos = 0; m_dig = '0; m_dp = '0; m_stg = '0; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 8'hFF; e_frame = 1'b0;
    end else begin
      fr = en && (m_pos == FP - 1);
      cm = m_pend && (fr || !en);
      if (cm) {m_dp, m_dig} = m_stg;
      if (load) begin
        m_stg = {dp_in, digits};
        m_pend = 1'b1;
      end else if (cm) begin
        m_pend = 1'b0;
      end
      m_pos = en ? (m_pos + 1) % FP : 0;
      e_frame = fr;
      off = m_pos % T;
      dg  = m_pos / T;
      if (!en || off < G) begin
        e_an = 4'hF; e_seg = 8'hFF;
      end else begin
        e_an  = ~(4'b0001 << dg);
        e_seg = {~m_dp[dg], exp_pat(m_dig, dg)};
      end
    end
  end

  task automatic wait_pos(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FP && !ok; i++) begin
      if (m_pos == p) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state an=%b seg=%b frame=%b pend=%b expected an=1111 seg=11111111 frame=0 pend=0", an, seg, frame, pend);
      end
    end
  endtask

  task automatic test_scan();
    int nfr;
    logic [7:0] want;
    nfr = 0;
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 2 * FP; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL scan_model cyc=%0d got an=%b seg=%b frame=%b pend=%b expected an=%b seg=%b frame=%b pend=%b", i, an, seg, frame, pend, e_an, e_seg, e_frame, m_pend);
      end
      if (frame) nfr++;
      if (an != 4'hF) begin
        want = 8'hC0;
`ifdef DISP_LZB_EN
        if (an != 4'b1110) want = 8'hFF;
`endif
        checks++;
        if (seg !== want) begin
          errors++;
          $display("FAIL scan_zero_seg an=%b got seg=%b expected %b", an, seg, want);
        end
      end
    end
    checks++;
    if (nfr != 2) begin
      errors++;
      $display("FAIL scan_frame_count got %0d expected 2", nfr);
    end
  endtask

  task automatic test_load_commit();
    bit ok, got;
    wait_pos(T + 3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_wait_pos timed out got 0 expected 1"); end
    load = 1'b1; digits = 16'h1234; dp_in = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL load_pend got %b expected 1", pend); end
    got = 1'b0;
    for (int i = 0; i < 2 * FP && !got; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL load_model got an=%b seg=%b frame=%b pend=%b expected an=%b seg=%b frame=%b pend=%b", an, seg, frame, pend, e_an, e_seg, e_frame, m_pend);
      end
      if (frame) got = 1'b1;
    end
    checks++;
    if (!got || pend !== 1'b0) begin
      errors++;
      $display("FAIL load_commit frame_seen=%b pend=%b expected frame_seen=1 pend=0", got, pend);
    end
    for (int i = 0; i < FP; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL load_show_model got an=%b seg=%b expected an=%b seg=%b", an, seg, e_an, e_seg);
      end
      if (an == 4'b1110) begin
        checks++;
        if (seg !== 8'b0_0011001) begin errors++; $display("FAIL load_digit0 got seg=%b expected 00011001", seg); end
      end
      if (an == 4'b0111) begin
        checks++;
        if (seg !== 8'b1_1111001) begin errors++; $display("FAIL load_digit3 got seg=%b expected 11111001", seg); end
      end
    end
  endtask

  task automatic test_collision();
    bit ok;
    int nfr;
    logic [7:0] want;
    wait_pos(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coll_wait_a timed out got 0 expected 1"); end
    load = 1'b1; digits = 16'hAAAA; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    wait_pos(FP - 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coll_wait_b timed out got 0 expected 1"); end
    load = 1'b1; digits = 16'h5555; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (frame !== 1'b1 || pend !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge got frame=%b pend=%b expected frame=1 pend=1", frame, pend);
    end
    nfr = 0;
    for (int i = 0; i < 2 * FP; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL coll_model got an=%b seg=%b frame=%b pend=%b expected an=%b seg=%b frame=%b pend=%b", an, seg, frame, pend, e_an, e_seg, e_frame, m_pend);
      end
      if (frame) begin
        nfr++;
        checks++;
        if (pend !== 1'b0) begin errors++; $display("FAIL coll_pend_clear got %b expected 0", pend); end
      end
      if (an == 4'b1110) begin
        want = (nfr == 0) ? 8'h88 : 8'h92;
        checks++;
        if (seg !== want) begin errors++; $display("FAIL coll_digit0 frame=%0d got seg=%b expected %b", nfr, seg, want); end
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    wait_pos(2 * T + 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL en_wait_pos timed out got 0 expected 1"); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg, frame} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL en_drop got an=%b seg=%b frame=%b expected an=1111 seg=11111111 frame=0", an, seg, frame);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL en_off_model got an=%b seg=%b expected an=%b seg=%b", an, seg, e_an, e_seg);
      end
    end
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL en_blank0 got an=%b expected 1111", an); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL en_blank1 got an=%b seg=%b expected an=1111 seg=11111111", an, seg); end
    @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL en_first_digit got an=%b expected 1110", an); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_pos(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstm_wait_a timed out got 0 expected 1"); end
    load = 1'b1; digits = 16'h9876; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    wait_pos(3 * T + 3, ok);
    checks++;
    if (!ok || pend !== 1'b1) begin errors++; $display("FAIL rstm_pend_before got ok=%b pend=%b expected ok=1 pend=1", ok, pend); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({an, seg, frame, pend} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstm_state got an=%b seg=%b frame=%b pend=%b expected an=1111 seg=11111111 frame=0 pend=0", an, seg, frame, pend);
    end
    for (int i = 0; i < FP + 4; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL rstm_model got an=%b seg=%b frame=%b pend=%b expected an=%b seg=%b frame=%b pend=%b", an, seg, frame, pend, e_an, e_seg, e_frame, m_pend);
      end
      if (an == 4'b1110) begin
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL rstm_shadow_zero got seg=%b expected 11000000", seg); end
      end
    end
  endtask

`ifdef DISP_LZB_EN
  task automatic test_lzb();
    bit ok, got;
    logic [6:0] w [4];
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        w[3] = 7'h7F; w[2] = 7'h7F; w[1] = 7'b0011001; w[0] = 7'b0100100;
      end else begin
        w[3] = 7'h7F; w[2] = 7'h7F; w[1] = 7'h7F; w[0] = 7'b1000000;
      end
      wait_pos(3, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lzb_wait timed out got 0 expected 1"); end
      load = 1'b1; digits = (v == 0) ? 16'h0042 : 16'h0000; dp_in = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 2 * FP && !got; i++) begin
        @(negedge clk);
        if (frame) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL lzb_frame got 0 expected 1"); end
      for (int i = 0; i < FP; i++) begin
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
          if (an == ~(4'b0001 << d)) begin
            checks++;
            if (seg !== {1'b1, w[d]}) begin
              errors++;
              $display("FAIL lzb_digit val=%0d digit=%0d got seg=%b expected %b", v, d, seg, {1'b1, w[d]});
            end
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      en     = ($urandom_range(0, 99) != 0);
      load   = ($urandom_range(0, 9) == 0);
      digits = 16'($urandom);
      dp_in  = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({an, seg, frame, pend} !== {e_an, e_seg, e_frame, m_pend}) begin
        errors++;
        $display("FAIL rand_model cyc=%0d got an=%b seg=%b frame=%b pend=%b expected an=%b seg=%b frame=%b pend=%b", i, an, seg, frame, pend, e_an, e_seg, e_frame, m_pend);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
    test_reset();
    test_scan();
    test_load_commit();
    test_collision();
    test_enable_drop();
    test_reset_mid();
`ifdef DISP_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller that time-shares one 7-segment pattern bus across four common-anode digits. It holds a tear-free shadow copy of a 16-bit hex value and cycles a refresh slot per digit, with a blanking guard interval that prevents ghosting between digits. It sits between the value producer (counter, register file or host logic) and the board's anode/segment pins. It supersedes one-shot, single-digit decoding at the top level.

## Interface
- TICK_DIV, 50000: clock cycles per digit slot; must be ≥2.
- GUARD, 500: blank cycles at the start of each slot; must be < TICK_DIV.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  scan enable; low forces blank and restarts the scan.
- LOAD  in  1  one-cycle strobe that stages DIGITS and DP_IN.
- DIGITS  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- DP_IN  in  4  decimal point per digit, active-high request.
- AN  out  4  digit enables, active-low.
- SEG  out  8  segments, active-low; [6:0] = g..a, [7] = DP.
- FRAME  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.
- PEND  out  1  staged value waiting for the next frame boundary.

## Operation
- Reset values:
  - AN=4'b1111, SEG=8'hFF, FRAME=0, PEND=0.
  - Shadow and staged registers = 0.
  - Slot counter cnt=0, digit index idx=0, state BLANK.
- State machine has two states, BLANK and ON.
  - BLANK while cnt<GUARD: AN=1111, SEG=FF. Move to ON when cnt reaches GUARD.
  - ON while GUARD≤cnt≤TICK_DIV-1: AN[idx]=0 and the others are 1; SEG[6:0]=decode(shadow nibble idx); SEG[7]=~DP_shadow[idx].
  - At cnt=TICK_DIV-1: cnt←0, idx←idx+1 (3 wraps to 0), state←BLANK.
- Decode patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- LOAD: staged←{DP_IN,DIGITS}, PEND←1. A repeated LOAD before commit overwrites staged (last one wins).
- Frame boundary (idx 3→0): FRAME=1 for one cycle. If PEND=1, shadow←staged and PEND←0.
- LOAD on the same cycle as a frame boundary:
  - The commit uses the staged content from before this cycle.
  - The new value is staged, and PEND stays 1 for the next frame.
- EN=0:
  - Next cycle: AN=1111, SEG=FF; cnt←0, idx←0, state BLANK; FRAME=0.
  - LOAD is still accepted. A pending value commits immediately while EN=0, so restart shows fresh data.
- EN 0→1: the scan starts at digit 0 with a full GUARD interval.
- RST mid-slot: all registers return to reset values on the next edge. A pending LOAD is discarded.

## Timing
- All outputs are registered and change one cycle after the cnt/idx condition that causes them.
- Per slot: exactly GUARD cycles blank, then TICK_DIV-GUARD cycles driven.
- Frame period is 4·TICK_DIV cycles.
- FRAME coincides with the first blank cycle of digit 0.
- LOAD-to-display latency: from commit at the next frame boundary, plus GUARD+1 cycles until digit 0 shows the new value. The worst case is just under 4·TICK_DIV + GUARD + 1 cycles.
- cnt width is $clog2(TICK_DIV). No arithmetic overflow is possible.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking is enabled.
  - Digits more significant than the highest non-zero nibble of the shadow drive SEG[6:0]=1111111.
  - Their AN timing and DP are unchanged.
  - Digit 0 is never blanked, so value 0 shows "0".
- DISP_LZB_EN undefined: every digit is always decoded; 0x0042 shows "0042".

## Structure
- Package disp_pkg:
  - NDIG=4.
  - SEG_BLANK=7'b1111111.
  - 16-entry segment pattern constant array.
  - Scan state enum {BLANK, ON}.
- Sub-module seg7_decode: combinational 4-bit to 7-bit lookup using the disp_pkg array. It is instantiated once on the muxed nibble.

## Test plan
Bench parameters: TICK_DIV=8, GUARD=2.
- Reset and scan: RST high for 3 cycles, then EN=1 with no LOAD.
  - AN=1111 and SEG=FF during reset.
  - Each slot: 2 cycles of AN=1111, then 6 cycles with AN stepping 1110, 1101, 1011, 0111; SEG[6:0]=1000000.
  - FRAME every 32 cycles.
- Load commit: LOAD with DIGITS=16'h1234, DP_IN=4'b0001 mid-frame.
  - PEND=1 until the next FRAME, then 0.
  - From that frame, digit 0 shows SEG=0_0011001 (4 with DP on), and digit 3 shows 1_1111001.
- Boundary collision: LOAD 16'hAAAA, then LOAD 16'h5555 on the FRAME cycle.
  - AAAA commits at that boundary; PEND stays 1.
  - 5555 appears after the following FRAME.
- Enable drop: EN=0 in the middle of digit 2.
  - Next cycle AN=1111, SEG=FF.
  - On EN=1, digit 0 is driven after exactly 2 blank cycles.
- Reset mid-operation: RST during digit 3 with PEND=1.
  - Outputs go to reset values; PEND=0; shadow=0.
- Leading-zero blanking (DISP_LZB_EN): load 16'h0042.
  - Digits 3 and 2 show SEG[6:0]=1111111; digits 1 and 0 show 4 and 2.
  - Loading 16'h0000 shows blank, blank, blank, 0.
